// File: rtl/reset_seq_pkg.sv
// Shared types and per-state output decode for the reset-node sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    StRun     = 3'b000,
    StQuiesce = 3'b001,
    StAssert  = 3'b010,
    StHeld    = 3'b011,
    StWarmup  = 3'b100,
    StRelease = 3'b101
  } seq_state_t;

  // {quiesce_req, domain_resetn, domain_clken, stopped, started}
  localparam logic [4:0] OutRun     = 5'b01101;
  localparam logic [4:0] OutQuiesce = 5'b11100;
  localparam logic [4:0] OutAssert  = 5'b00100;
  localparam logic [4:0] OutHeld    = 5'b00010;
  localparam logic [4:0] OutWarmup  = 5'b00100;
  localparam logic [4:0] OutRelease = 5'b01100;

  function automatic logic [4:0] state_outputs(seq_state_t s);
    logic [4:0] o;
    o = OutHeld;
    case (s)
      StRun:     o = OutRun;
      StQuiesce: o = OutQuiesce;
      StAssert:  o = OutAssert;
      StHeld:    o = OutHeld;
      StWarmup:  o = OutWarmup;
      StRelease: o = OutRelease;
      default:   o = OutHeld;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// Loadable down-counter shared by every timed phase of the sequencer.
module reset_seq_counter
  import reset_seq_pkg::*;
#(
  parameter int unsigned CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_node_sequencer.sv
// Sequences one reset domain through quiesce, reset, clock gating, warm-up and release.
// Optional quiesce timeout: define RESET_SEQ_QUIESCE_TIMEOUT_EN.
module reset_node_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned ASSERT_CYCLES   = 4,
  parameter int unsigned WARMUP_CYCLES   = 4,
  parameter int unsigned RELEASE_CYCLES  = 8,
  parameter int unsigned QUIESCE_TIMEOUT = 64
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic stop_req,
  input  logic start_req,
  input  logic quiesce_ack,
  output logic quiesce_req,
  output logic domain_resetn,
  output logic domain_clken,
  output logic stopped,
  output logic started,
  output logic timeout_flag
);

  if (ASSERT_CYCLES < 1 || ASSERT_CYCLES > (2 ** CNT_W)) begin : g_bad_assert
    $error("ASSERT_CYCLES out of range");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > (2 ** CNT_W)) begin : g_bad_warmup
    $error("WARMUP_CYCLES out of range");
  end
  if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > (2 ** CNT_W)) begin : g_bad_release
    $error("RELEASE_CYCLES out of range");
  end
  if (QUIESCE_TIMEOUT < 1 || QUIESCE_TIMEOUT > (2 ** CNT_W)) begin : g_bad_timeout
    $error("QUIESCE_TIMEOUT out of range");
  end

  localparam logic [CNT_W-1:0] AssertLoad  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WarmupLoad  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ReleaseLoad = CNT_W'(RELEASE_CYCLES - 1);

  seq_state_t       state_d, state_q;
  logic [4:0]       out_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] QuiesceLoad = CNT_W'(QUIESCE_TIMEOUT - 1);
  logic timeout_set, timeout_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
    timeout_set  = 1'b0;
`endif
    unique case (state_q)
      StRun: begin
        if (stop_req) begin
          state_d = StQuiesce;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
          cnt_load     = 1'b1;
          cnt_load_val = QuiesceLoad;
`endif
        end
      end
      StQuiesce: begin
        if (quiesce_ack) begin
          state_d      = StAssert;
          cnt_load     = 1'b1;
          cnt_load_val = AssertLoad;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
        end else if (cnt_zero) begin
          // Domain never drained: force it into reset anyway and remember why.
          state_d      = StAssert;
          cnt_load     = 1'b1;
          cnt_load_val = AssertLoad;
          timeout_set  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      StAssert: begin
        if (cnt_zero) state_d = StHeld;
        else          cnt_dec = 1'b1;
      end
      StHeld: begin
        if (start_req) begin
          state_d      = StWarmup;
          cnt_load     = 1'b1;
          cnt_load_val = WarmupLoad;
        end
      end
      StWarmup: begin
        if (cnt_zero) begin
          state_d      = StRelease;
          cnt_load     = 1'b1;
          cnt_load_val = ReleaseLoad;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StRelease: begin
        if (cnt_zero) state_d = StRun;
        else          cnt_dec = 1'b1;
      end
      default: state_d = StHeld;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q <= StHeld;
      out_q   <= OutHeld;
    end else begin
      state_q <= state_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign {quiesce_req, domain_resetn, domain_clken, stopped, started} = out_q;

`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end
  end
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  reset_seq_counter #(
    .CntW (CNT_W)
  ) u_counter (
    .clk_i      (clock),
    .rst_ni     (async_resetn),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

endmodule

// File: tb/tb_reset_node_sequencer.sv
// Directed self-checking bench for reset_node_sequencer (default phase lengths, timeout 16).
module tb_reset_node_sequencer;

  logic clock = 1'b0;
  logic async_resetn;
  logic stop_req, start_req, quiesce_ack;
  logic quiesce_req, domain_resetn, domain_clken, stopped, started, timeout_flag;
  logic [4:0] outs;

  int errors = 0;
  int checks = 0;

  // Expected vectors: {quiesce_req, domain_resetn, domain_clken, stopped, started}
  localparam logic [4:0] ExpRun     = 5'b01101;
  localparam logic [4:0] ExpQuiesce = 5'b11100;
  localparam logic [4:0] ExpAssert  = 5'b00100;
  localparam logic [4:0] ExpHeld    = 5'b00010;
  localparam logic [4:0] ExpWarmup  = 5'b00100;
  localparam logic [4:0] ExpRelease = 5'b01100;

  assign outs = {quiesce_req, domain_resetn, domain_clken, stopped, started};

  always #5 clock = ~clock;

  reset_node_sequencer #(
    .CNT_W           (8),
    .ASSERT_CYCLES   (4),
    .WARMUP_CYCLES   (4),
    .RELEASE_CYCLES  (8),
    .QUIESCE_TIMEOUT (16)
  ) dut (
    .clock         (clock),
    .async_resetn  (async_resetn),
    .stop_req      (stop_req),
    .start_req     (start_req),
    .quiesce_ack   (quiesce_ack),
    .quiesce_req   (quiesce_req),
    .domain_resetn (domain_resetn),
    .domain_clken  (domain_clken),
    .stopped       (stopped),
    .started       (started),
    .timeout_flag  (timeout_flag)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bring-up expectation k edges after start_req is sampled in HELD.
  function automatic logic [4:0] bringup_exp(int k);
    if (k <= 4)  return ExpWarmup;
    if (k <= 12) return ExpRelease;
    return ExpRun;
  endfunction

  task automatic test_reset();
    async_resetn = 1'b0;
    stop_req     = 1'b0;
    start_req    = 1'b0;
    quiesce_ack  = 1'b0;
    #12;
    checks++;
    if (outs !== ExpHeld || timeout_flag !== 1'b0) begin
      $display("FAIL reset_values got=%b/%b exp=%b/0", outs, timeout_flag, ExpHeld);
      errors++;
    end
    @(negedge clock);
    async_resetn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (outs !== ExpHeld || timeout_flag !== 1'b0) begin
        $display("FAIL power_on_hold k=%0d got=%b/%b exp=%b/0", k, outs, timeout_flag, ExpHeld);
        errors++;
      end
    end
  endtask

  task automatic test_bringup();
    start_req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) start_req = 1'b0;
      checks++;
      if (outs !== bringup_exp(k)) begin
        $display("FAIL bringup k=%0d got=%b exp=%b", k, outs, bringup_exp(k));
        errors++;
      end
    end
  endtask

  task automatic test_shutdown_slow_ack();
    logic [4:0] exp;
    quiesce_ack = 1'b0;
    stop_req    = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1)  stop_req = 1'b0;
      // Ack arrives 10 cycles after QUIESCE entry, sampled on edge 12.
      if (k == 11) quiesce_ack = 1'b1;
      if (k <= 11)      exp = ExpQuiesce;
      else if (k <= 15) exp = ExpAssert;
      else              exp = ExpHeld;
      checks++;
      if (outs !== exp) begin
        $display("FAIL shutdown_slow_ack k=%0d got=%b exp=%b", k, outs, exp);
        errors++;
      end
    end
    quiesce_ack = 1'b0;
  endtask

  task automatic test_mid_sequence();
    logic [4:0] exp;
    quiesce_ack = 1'b1;
    start_req   = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 2) begin
        start_req = 1'b0;
        stop_req  = 1'b1;
      end
      if (k <= 13)      exp = bringup_exp(k);
      else if (k == 14) exp = ExpQuiesce;
      else if (k <= 18) exp = ExpAssert;
      else              exp = ExpHeld;
      checks++;
      if (outs !== exp) begin
        $display("FAIL mid_sequence k=%0d got=%b exp=%b", k, outs, exp);
        errors++;
      end
    end
    stop_req    = 1'b0;
    quiesce_ack = 1'b0;
  endtask

  task automatic test_reset_mid_release();
    start_req = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    start_req = 1'b0;
    checks++;
    if (outs !== ExpRelease) begin
      $display("FAIL release_before_reset got=%b exp=%b", outs, ExpRelease);
      errors++;
    end
    #2;
    async_resetn = 1'b0;
    #1;
    checks++;
    if (outs !== ExpHeld) begin
      $display("FAIL async_reset_immediate got=%b exp=%b", outs, ExpHeld);
      errors++;
    end
    tick();
    tick();
    async_resetn = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (outs !== ExpHeld || started !== 1'b0) begin
        $display("FAIL no_started_after_reset k=%0d got=%b exp=%b", k, outs, ExpHeld);
        errors++;
      end
    end
  endtask

  task automatic test_timeout();
    start_req = 1'b1;
    for (int k = 1; k <= 13; k++) tick();
    start_req = 1'b0;
    checks++;
    if (outs !== ExpRun) begin
      $display("FAIL timeout_setup_run got=%b exp=%b", outs, ExpRun);
      errors++;
    end
    quiesce_ack = 1'b0;
    stop_req    = 1'b1;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
    begin
      logic [4:0] exp;
      logic       exp_flag;
      for (int k = 1; k <= 21; k++) begin
        tick();
        if (k == 1) stop_req = 1'b0;
        if (k <= 16)      exp = ExpQuiesce;
        else if (k <= 20) exp = ExpAssert;
        else              exp = ExpHeld;
        exp_flag = (k >= 17);
        checks++;
        if (outs !== exp || timeout_flag !== exp_flag) begin
          $display("FAIL quiesce_timeout k=%0d got=%b/%b exp=%b/%b",
                   k, outs, timeout_flag, exp, exp_flag);
          errors++;
        end
      end
      start_req = 1'b1;
      for (int k = 1; k <= 13; k++) begin
        tick();
        if (k == 1) start_req = 1'b0;
        checks++;
        if (outs !== bringup_exp(k) || timeout_flag !== 1'b1) begin
          $display("FAIL timeout_sticky k=%0d got=%b/%b exp=%b/1",
                   k, outs, timeout_flag, bringup_exp(k));
          errors++;
        end
      end
    end
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) stop_req = 1'b0;
      checks++;
      if (outs !== ExpQuiesce || timeout_flag !== 1'b0) begin
        $display("FAIL quiesce_waits k=%0d got=%b/%b exp=%b/0",
                 k, outs, timeout_flag, ExpQuiesce);
        errors++;
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_shutdown_slow_ack();
    test_mid_sequence();
    test_reset_mid_release();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
